// File: rtl/cpu_mem_axi_master.sv
// Single-outstanding AXI4 master: turns one CPU load/store into one single-beat AXI
// transaction and pulses done_o (with err_o) when the response has been taken.
module cpu_mem_axi_master #(
    parameter logic [3:0] ID_VAL = 4'd0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        wstrb_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic [3:0]        ARID_M,
    output logic [ADDR_W-1:0] ARADDR_M,
    output logic [3:0]        ARLEN_M,
    output logic [2:0]        ARSIZE_M,
    output logic [1:0]        ARBURST_M,
    output logic              ARVALID_M,
    input  logic              ARREADY_M,
    input  logic [3:0]        RID_M,
    input  logic [DATA_W-1:0] RDATA_M,
    input  logic [1:0]        RRESP_M,
    input  logic              RLAST_M,
    input  logic              RVALID_M,
    output logic              RREADY_M,
    output logic [3:0]        AWID_M,
    output logic [ADDR_W-1:0] AWADDR_M,
    output logic [3:0]        AWLEN_M,
    output logic [2:0]        AWSIZE_M,
    output logic [1:0]        AWBURST_M,
    output logic              AWVALID_M,
    input  logic              AWREADY_M,
    output logic [DATA_W-1:0] WDATA_M,
    output logic [3:0]        WSTRB_M,
    output logic              WLAST_M,
    output logic              WVALID_M,
    input  logic              WREADY_M,
    input  logic [3:0]        BID_M,
    input  logic [1:0]        BRESP_M,
    input  logic              BVALID_M,
    output logic              BREADY_M
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LSB_MASK = ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              rready_q, rready_d;
    logic              bready_q, bready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              aw_ok, w_ok;

    // A channel counts as finished once its VALID has dropped or is handshaking now.
    assign aw_ok = !awvalid_q || AWREADY_M;
    assign w_ok  = !wvalid_q  || WREADY_M;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wstrb_q   <= wstrb_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rready_q  <= rready_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_i)           state_d = we_i ? WR_AW : RD_A;
            RD_A:    if (ARREADY_M)       state_d = RD_D;
            RD_D:    if (RVALID_M)        state_d = IDLE;
            WR_AW:   if (aw_ok && w_ok)   state_d = WR_B;
            WR_B:    if (BVALID_M)        state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        arvalid_d = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        rready_d  = 1'b0;
        bready_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d    = addr_i & ~ADDR_LSB_MASK;
                    wdata_d   = wdata_i;
                    wstrb_d   = wstrb_i;
                    arvalid_d = !we_i;
                    awvalid_d = we_i;
                    wvalid_d  = we_i;
                end
            end
            RD_A: begin
                arvalid_d = !ARREADY_M;
                rready_d  = ARREADY_M;
            end
            RD_D: begin
                rready_d = !RVALID_M;
                if (RVALID_M) begin
                    rdata_d = RDATA_M;
                    done_d  = 1'b1;
                    err_d   = (RRESP_M != 2'b00) || (RID_M != ID_VAL) || !RLAST_M;
                end
            end
            WR_AW: begin
                awvalid_d = awvalid_q && !AWREADY_M;
                wvalid_d  = wvalid_q && !WREADY_M;
                bready_d  = aw_ok && w_ok;
            end
            WR_B: begin
                bready_d = !BVALID_M;
                if (BVALID_M) begin
                    done_d = 1'b1;
                    err_d  = (BRESP_M != 2'b00) || (BID_M != ID_VAL);
                end
            end
            default: ;
        endcase
    end

    assign rdata_o   = rdata_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign ARID_M    = ID_VAL;
    assign ARADDR_M  = addr_q;
    assign ARLEN_M   = 4'd0;
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = 2'b01;
    assign ARVALID_M = arvalid_q;
    assign RREADY_M  = rready_q;
    assign AWID_M    = ID_VAL;
    assign AWADDR_M  = addr_q;
    assign AWLEN_M   = 4'd0;
    assign AWSIZE_M  = 3'b010;
    assign AWBURST_M = 2'b01;
    assign AWVALID_M = awvalid_q;
    assign WDATA_M   = wdata_q;
    assign WSTRB_M   = wstrb_q;
    assign WLAST_M   = 1'b1;
    assign WVALID_M  = wvalid_q;
    assign BREADY_M  = bready_q;

endmodule
